// File: rtl/stoch_signed_col_rowseq.sv
// stoch_signed_col_rowseq
// Snapshots one signed (p/m) stochastic col matrix on a start pulse and then
// streams it to the MAC array one row per ready/valid handshake. The outputs
// are registered, so the wide combinational im2col cone stays isolated from
// a possibly stalling downstream consumer.
//
// Optional build macro: STOCH_ROWSEQ_CANCEL_EN
//   When defined, every output bit pair with p=1 and m=1 is emitted as
//   p=0, m=0 (the value p-m is unchanged, fewer active bits reach the MAC).
//   The snapshot itself is never modified. When undefined, rows are bit-exact.
//
// Note: nRST is an active-high synchronous reset despite its name.

module stoch_signed_col_rowseq #(
  parameter int COL_HEIGHT = 16,
  parameter int COL_WIDTH  = 9,
  parameter int IDX_W      = (COL_HEIGHT > 1) ? $clog2(COL_HEIGHT) : 1
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic                            start,
  input  logic [COL_HEIGHT*COL_WIDTH-1:0] col_p,
  input  logic [COL_HEIGHT*COL_WIDTH-1:0] col_m,
  input  logic                            row_ready,
  output logic                            row_valid,
  output logic [COL_WIDTH-1:0]            row_p,
  output logic [COL_WIDTH-1:0]            row_m,
  output logic [IDX_W-1:0]                row_idx,
  output logic                            row_last,
  output logic                            busy,
  output logic                            done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COL_HEIGHT - 1);

  state_t state_q, state_d;

  // Snapshot of the whole matrix, one entry per col row
  logic [COL_WIDTH-1:0] snap_p_q [COL_HEIGHT];
  logic [COL_WIDTH-1:0] snap_m_q [COL_HEIGHT];

  // Registered output row
  logic                 row_valid_q;
  logic                 row_last_q;
  logic [COL_WIDTH-1:0] row_p_q, row_p_d;
  logic [COL_WIDTH-1:0] row_m_q, row_m_d;
  logic [IDX_W-1:0]     row_idx_q, row_idx_d;

  logic                 capture_en;
  logic                 handshake;
  logic                 at_last;
  logic                 load_row;
  logic                 finish_pass;
  logic [COL_WIDTH-1:0] sel_p, sel_m;

  assign capture_en  = (state_q == S_IDLE) && start;
  assign handshake   = row_valid_q && row_ready;
  assign at_last     = (row_idx_q == LAST_IDX);
  assign finish_pass = (state_q == S_STREAM) && handshake && at_last;
  // Row 0 is loaded in LOAD; subsequent rows on each non-last handshake
  assign load_row    = (state_q == S_LOAD) ||
                       ((state_q == S_STREAM) && handshake && !at_last);

  // FSM state register
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; start outside IDLE is deliberately ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   state_d = S_STREAM;
      S_STREAM: if (handshake && at_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_LOAD:   busy = 1'b1;
      S_STREAM: busy = 1'b1;
      S_DONE:   done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Snapshot capture: each row sliced out of the row-major flat input
  generate
    for (genvar gi = 0; gi < COL_HEIGHT; gi++) begin : g_snap
      // Hold one snapshot row; only rewritten by a start accepted in IDLE
      always_ff @(posedge CLK) begin
        if (nRST) begin
          snap_p_q[gi] <= '0;
          snap_m_q[gi] <= '0;
        end else if (capture_en) begin
          snap_p_q[gi] <= col_p[gi*COL_WIDTH +: COL_WIDTH];
          snap_m_q[gi] <= col_m[gi*COL_WIDTH +: COL_WIDTH];
        end
      end
    end
  endgenerate

  // Select the row to present next and apply optional p/m cancellation
  always_comb begin
    row_idx_d = '0;
    if ((state_q == S_STREAM) && !at_last) begin
      row_idx_d = row_idx_q + IDX_W'(1);
    end
    sel_p = snap_p_q[row_idx_d];
    sel_m = snap_m_q[row_idx_d];
`ifdef STOCH_ROWSEQ_CANCEL_EN
    row_p_d = sel_p & ~sel_m;
    row_m_d = sel_m & ~sel_p;
`else
    row_p_d = sel_p;
    row_m_d = sel_m;
`endif
  end

  // Output row register: advance on load, drop valid after the last handshake
  always_ff @(posedge CLK) begin
    if (nRST) begin
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
      row_p_q     <= '0;
      row_m_q     <= '0;
      row_idx_q   <= '0;
    end else if (load_row) begin
      row_valid_q <= 1'b1;
      row_last_q  <= (row_idx_d == LAST_IDX);
      row_p_q     <= row_p_d;
      row_m_q     <= row_m_d;
      row_idx_q   <= row_idx_d;
    end else if (finish_pass) begin
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
    end
  end

  assign row_valid = row_valid_q;
  assign row_last  = row_last_q;
  assign row_p     = row_p_q;
  assign row_m     = row_m_q;
  assign row_idx   = row_idx_q;

endmodule

// File: tb/tb_stoch_signed_col_rowseq.sv
// Directed self-checking bench for stoch_signed_col_rowseq (16 rows x 9 bits).
// Row r of col_p holds r and row r of col_m holds ~r (9-bit), so every
// presented row can be checked against its index.

module tb_stoch_signed_col_rowseq;

  localparam int H = 16;
  localparam int W = 9;
  localparam int IW = 4;

  logic           CLK = 1'b0;
  logic           nRST;
  logic           start;
  logic [H*W-1:0] col_p;
  logic [H*W-1:0] col_m;
  logic           row_ready;
  logic           row_valid;
  logic [W-1:0]   row_p;
  logic [W-1:0]   row_m;
  logic [IW-1:0]  row_idx;
  logic           row_last;
  logic           busy;
  logic           done;

  int n_tests = 0;
  int n_fail  = 0;

  stoch_signed_col_rowseq #(
    .COL_HEIGHT(H),
    .COL_WIDTH (W)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .start    (start),
    .col_p    (col_p),
    .col_m    (col_m),
    .row_ready(row_ready),
    .row_valid(row_valid),
    .row_p    (row_p),
    .row_m    (row_m),
    .row_idx  (row_idx),
    .row_last (row_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: got sim time limit expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_default();
    for (int r = 0; r < H; r++) begin
      col_p[r*W +: W] = W'(r);
      col_m[r*W +: W] = ~W'(r);
    end
  endtask

  // Pulse start for one edge, then pass through LOAD so row 0 is presented
  task automatic start_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic check_row(input string tag, input int r);
    logic [W-1:0] ep, em;
    ep = W'(r);
    em = ~W'(r);
    chk({tag, "_valid"}, 32'(row_valid), 32'd1);
    chk({tag, "_idx"},   32'(row_idx),   32'(r));
    chk({tag, "_p"},     32'(row_p),     32'(ep));
    chk({tag, "_m"},     32'(row_m),     32'(em));
    chk({tag, "_last"},  32'(row_last),  (r == H - 1) ? 32'd1 : 32'd0);
    $display("[TB] %s row %0d p=%03h m=%03h last=%0b", tag, row_idx, row_p, row_m, row_last);
  endtask

  // Run to the end of a pass with a bounded wait on done
  task automatic drain(input string tag);
    int n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    int n_done;
    nRST      = 1'b1;
    start     = 1'b0;
    row_ready = 1'b1;
    col_p     = '0;
    col_m     = '0;
    fill_default();

    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(row_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_idx",   32'(row_idx),   32'd0);
    chk("rst_last",  32'(row_last),  32'd0);
    chk("rst_p",     32'(row_p),     32'd0);
    $display("[TB] reset checked");
    nRST = 1'b0;
    tick();

    // Full-throughput pass: start edge, LOAD, 16 rows, then done
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ft_busy_load",  32'(busy),      32'd1);
    chk("ft_valid_load", 32'(row_valid), 32'd0);
    tick();
    for (int r = 0; r < H; r++) begin
      check_row("ft", r);
      chk("ft_nodone", 32'(done), 32'd0);
      tick();
    end
    chk("ft_done",       32'(done),      32'd1);
    chk("ft_busy_end",   32'(busy),      32'd0);
    chk("ft_valid_end",  32'(row_valid), 32'd0);
    tick();
    chk("ft_done_pulse", 32'(done), 32'd0);
    $display("[TB] full-throughput pass complete");

    // Backpressure at row 3
    start_pass();
    for (int r = 0; r < 3; r++) tick();
    row_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_row("bp_hold", 3);
    end
    row_ready = 1'b1;
    tick();
    check_row("bp_resume", 4);
    drain("bp");

    // Snapshot isolation and ignored start at row 7
    start_pass();
    for (int r = 0; r < 7; r++) tick();
    for (int r = 7; r < H; r++) begin
      check_row("iso", r);
      if (r == 7) begin
        col_p = '1;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("iso_done", 32'(done), 32'd1);
    n_done = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done) n_done++;
    end
    chk("iso_single_done", 32'(n_done), 32'd0);
    chk("iso_idle_busy",   32'(busy),   32'd0);
    fill_default();

    // Reset mid-stream at row 5
    start_pass();
    for (int r = 0; r < 5; r++) tick();
    chk("mr_pre_idx", 32'(row_idx), 32'd5);
    nRST = 1'b1;
    tick();
    nRST = 1'b0;
    chk("mr_valid", 32'(row_valid), 32'd0);
    chk("mr_busy",  32'(busy),      32'd0);
    chk("mr_idx",   32'(row_idx),   32'd0);
    chk("mr_done",  32'(done),      32'd0);
    n_done = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) n_done++;
    end
    chk("mr_no_done", 32'(n_done), 32'd0);
    start_pass();
    check_row("mr_replay", 0);
    drain("mr");

    // Overlapping p/m bits on row 0
    col_p[0 +: W] = 9'h1FF;
    col_m[0 +: W] = 9'h0F0;
    start_pass();
`ifdef STOCH_ROWSEQ_CANCEL_EN
    chk("cx_p", 32'(row_p), 32'h10F);
    chk("cx_m", 32'(row_m), 32'h000);
`else
    chk("cx_p", 32'(row_p), 32'h1FF);
    chk("cx_m", 32'(row_m), 32'h0F0);
`endif
    $display("[TB] cancel row 0 p=%03h m=%03h", row_p, row_m);
    tick();
    check_row("cx_row1", 1);
    drain("cx");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stoch_signed_col_rowseq.md
Name: stoch_signed_col_rowseq

Overview:
- Downstream neighbour of the signed stochastic im2col stage.
- Snapshots one full signed (p/m) col matrix on a start pulse, then streams it out one row per handshake to the stochastic signed MAC array.
- The registered ready/valid interface decouples the wide combinational im2col output from a MAC that may stall.
- One pass streams one stochastic bit-sample of the whole matrix; the controller re-starts it once per sample.

Parameters:
- COL_HEIGHT, 16, number of col rows (output positions) per matrix.
- COL_WIDTH, 9, bits per row (KERNEL_H*KERNEL_W*CHANNELS).
- IDX_W, $clog2(COL_HEIGHT) (min 1), width of row index output.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- nRST  input  1  synchronous, active-high reset; sampled on CLK rising edge.
- start  input  1  request to snapshot col_p/col_m and begin a pass.
- col_p  input  COL_HEIGHT*COL_WIDTH  positive-rail col matrix, row-major [row][bit].
- col_m  input  COL_HEIGHT*COL_WIDTH  negative-rail col matrix, same layout.
- row_ready  input  1  downstream can accept the current row.
- row_valid  output  1  row_p/row_m/row_idx hold a valid row.
- row_p  output  COL_WIDTH  positive-rail row data.
- row_m  output  COL_WIDTH  negative-rail row data.
- row_idx  output  IDX_W  index of the presented row, 0..COL_HEIGHT-1.
- row_last  output  1  high with row_valid when row_idx==COL_HEIGHT-1.
- busy  output  1  high in LOAD and STREAM.
- done  output  1  one-cycle pulse after the last row handshake.

Behaviour:
- Reset (nRST=1 at an edge):
  - state=IDLE; row_valid, row_last, busy, done = 0.
  - row_p, row_m, row_idx, and the snapshot registers = 0.
  - Reset wins over every other input in the same cycle, including mid-pass: the current pass is abandoned, no done is issued.
- States: IDLE, LOAD, STREAM, DONE.
- IDLE:
  - start=1 → capture col_p/col_m into snapshot registers at this edge → LOAD. busy=1 from the next cycle.
  - start=0 → stay in IDLE.
- LOAD: exactly one cycle.
  - Registers row 0 of the snapshot onto row_p/row_m; row_idx=0.
  - row_valid=1 from the next cycle → STREAM.
- STREAM:
  - A handshake occurs when row_valid && row_ready are high at an edge.
  - Non-last row handshake: row_idx+1, next snapshot row registered onto the outputs; row_valid stays 1. This gives one row per cycle at full throughput.
  - row_valid && !row_ready: row_p, row_m, row_idx, row_last held stable; no advance.
  - Last row (row_idx==COL_HEIGHT-1) handshake → DONE. row_valid and busy drop at the same edge.
- DONE: done=1 for exactly one cycle → IDLE.
- start while busy (LOAD/STREAM) is ignored; the snapshot is not overwritten.
- start during the DONE cycle is ignored; a new pass needs start in IDLE.
- Latency: start edge to first row_valid = 2 cycles.
  - Full pass with row_ready held 1: COL_HEIGHT+3 cycles from start to done (1 LOAD, COL_HEIGHT STREAM, 1 DONE, counting the start edge).
- Data path:
  - Output rows come only from the snapshot, so col_p/col_m changes after the start edge never affect the pass.
  - row_p[b] = snap_p[row_idx][b] and row_m[b] = snap_m[row_idx][b], bit-exact (subject to the optional feature below).
- COL_HEIGHT=1: LOAD → STREAM with row_last=1 immediately; one handshake → DONE.

Optional Feature:
- Macro: STOCH_ROWSEQ_CANCEL_EN.
- Defined: each output bit pair with p=1 and m=1 is emitted as p=0, m=0. The value (p−m)=0 is preserved; the downstream MAC sees fewer active bits. Applied when the row is registered onto the outputs; the snapshot is unchanged.
- Undefined: rows pass through bit-exact, including p=m=1 pairs.

Test Plan:
- Reset mid-stream:
  - Stimulus: start, advance to row_idx=5, then nRST=1 for 1 cycle.
  - Required: next cycle row_valid=0, busy=0, row_idx=0, no done pulse; a later start replays from row 0.
- Full-throughput pass:
  - Stimulus: COL_HEIGHT=16, row_ready=1, row r of col_p = r, col_m = ~r (9-bit).
  - Required: row_valid first 2 cycles after start; rows 0..15 on 16 consecutive cycles with matching data; row_last only on row 15; done 1 cycle after row 15; start to done = 19 cycles.
- Backpressure:
  - Stimulus: row_ready=0 for 4 cycles while row_idx=3.
  - Required: row_idx=3 and data stable for all 4 cycles; row 4 appears the cycle after row_ready returns to 1.
- Snapshot isolation and ignored start:
  - Stimulus: change col_p to all-ones and pulse start at row_idx=7.
  - Required: rows 7..15 still show the original data; the pass ends normally with a single done.
- Cancel feature:
  - Stimulus: row 0 with col_p=9'h1FF, col_m=9'h0F0.
  - Required with STOCH_ROWSEQ_CANCEL_EN: row_p=9'h10F, row_m=9'h000.
  - Required without the macro: row_p=9'h1FF, row_m=9'h0F0.
